line_window_ctrl: RTL
=====================

Name: line_window_ctrl

Overview:
- Streaming front-end that turns a raster pixel stream into vertical NLINES-tall pixel columns for the downstream stencil stage.
- Writes each incoming pixel into one of NLINES sramLine instances, chosen in rotation.
- In the same cycle it reads the same column from the other NLINES-1 lines, then emits the assembled column with a valid/ready handshake.
- Sits between the sensor/DMA pixel stream and the sramLine bank; it drives every sramLine port.

Parameters:
- WIDTH, 1920, pixels per line; also the sramLine depth.
- HEIGHT, 1080, lines per frame.
- NLINES, 3, window height; number of sramLine instances driven; minimum 2.
- DW, 48, pixel width (3 channels x 16 bits).
- AW, $clog2(WIDTH), column address width.
- HW, $clog2(HEIGHT), row counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_sof  in  1  start of frame; qualified by in_valid && in_ready.
- in_data  in  DW  pixel.
- sram_wen  out  NLINES  per-line write enable (sramLine port 0).
- sram_ren  out  NLINES  per-line read enable (sramLine port 1).
- sram_addr  out  AW  column address, shared by both ports of all lines.
- sram_d  out  DW  write data, shared by all lines.
- sram_q  in  NLINES x DW  port-1 read data; valid 1 cycle after ren; 0 when ren was low.
- col_valid  out  1  output column valid.
- col_ready  in  1  downstream accepts the column.
- col_data  out  NLINES x DW  [0] is the oldest row (y-NLINES+1), [NLINES-1] is row y.
- col_x  out  AW  column of the output.
- col_y  out  HW  row of the newest pixel.
- frame_done  out  1  one-cycle pulse when the last pixel (WIDTH-1, HEIGHT-1) is accepted.

Behaviour:
- Reset (async, rst=1):
  - x=0, y=0, wr_ptr=0, state=FILL.
  - Stage-1 valid cleared, output buffer emptied.
  - All outputs 0, including in_ready=0 while rst is high.
- Accept: a pixel is taken when in_valid && in_ready. In that cycle:
  - sram_wen[wr_ptr]=1, sram_addr=x, sram_d=in_data.
  - In STREAM, sram_ren=1 for every line except wr_ptr. In FILL, sram_ren=0.
- Stage 1 registers in_data, x, y and the read-line order. Next cycle, col_data[k] = sram_q[(wr_ptr+1+k) mod NLINES] for k < NLINES-1, and col_data[NLINES-1] = the registered pixel.
  - This is written into a 2-entry output buffer.
  - Latency from accept to col_valid is 2 cycles when the buffer is empty.
- Output buffer:
  - FIFO, depth 2.
  - col_valid = buffer non-empty. Outputs hold stable while col_valid && !col_ready.
- in_ready = (s1_valid + occupancy - (col_valid && col_ready)) < 2.
  - Comb path col_ready -> in_ready is allowed.
  - Guarantees 1 pixel/cycle when col_ready is held high.
  - Stage 1 never overwrites a full buffer.
- Counters:
  - x increments on each accept.
  - At x = WIDTH-1: x -> 0, y+1, wr_ptr = (wr_ptr+1) mod NLINES.
  - At (WIDTH-1, HEIGHT-1): frame_done pulses, x=y=wr_ptr=0, state=FILL.
- States:
  - FILL: y < NLINES-1. Write only; no stage-1 entry, no output.
  - FILL -> STREAM on the line wrap that makes y = NLINES-1.
  - STREAM -> FILL on frame end or on in_sof.
- in_sof accepted: the pixel is treated as (0,0) with wr_ptr=0 and state=FILL, regardless of the current counters. Entries already in stage 1 or the buffer still drain normally.
- Simultaneous read and write on the same line is impossible by construction: wr_ptr is excluded from ren.
- Reset mid-frame discards all in-flight columns. SRAM contents are not cleared.

Optional Feature:
- Macro: LINE_WINDOW_BORDER_REPLICATE_EN.
- Defined:
  - Rows 0..NLINES-2 also produce columns.
  - Any entry whose source row is < 0 takes the row-0 value: from sram_q of line 0, or from the incoming pixel when y==0.
  - One column per pixel, HEIGHT*WIDTH columns per frame.
- Undefined: columns only for y >= NLINES-1, i.e. (HEIGHT-NLINES+1)*WIDTH columns per frame.

Decomposition:
- Package line_window_pkg:
  - DW constant, pixel_t (logic [DW-1:0]).
  - state_t enum {FILL, STREAM}.
  - Function rot_idx(ptr, k, n) returning (ptr+1+k) mod n.
- Sub-module col_skid_buf: 2-entry valid/ready buffer carrying {col_data, col_x, col_y}; exposes its occupancy count.

Test Plan:
- WIDTH=8, HEIGHT=4, NLINES=3, pixel = {y,x}, col_ready=1, continuous input -> first col_valid 2 cycles after accepting (0,2); then 16 columns. Column (5,3) = {(5,1),(5,2),(5,3)}. frame_done on accept of (7,3).
- Same stream, col_ready toggles 1/0 every cycle -> no column lost or duplicated; in_ready low when the buffer is full; column order matches raster order.
- Row wrap -> wr_ptr sequence 0,1,2,0; sram_ren never set on wr_ptr; sram_addr = x.
- in_sof asserted at (3,2) of frame 1 -> counters restart at (0,0); no output until y=2 of the new frame.
- rst pulsed mid-row with 2 columns buffered -> col_valid=0 and in_ready=0 within the same cycle; after release, clean restart at (0,0).
- With LINE_WINDOW_BORDER_REPLICATE_EN: column (4,0) = {(4,0),(4,0),(4,0)}; column (4,1) = {(4,0),(4,0),(4,1)}; 32 columns per frame.

Source files
------------

// File: rtl/line_window_pkg.sv
// line_window_pkg: shared types and the read-line rotation helper for line_window_ctrl
package line_window_pkg;
  localparam int DW = 48;
  typedef logic [DW-1:0] pixel_t;
  typedef enum logic {FILL, STREAM} state_t;
  function automatic int rot_idx(input int ptr, input int k, input int n);
    return (ptr + 1 + k) % n;
  endfunction
endpackage

// File: rtl/col_skid_buf.sv
// col_skid_buf: 2-entry valid/ready FIFO for assembled columns, exposing its occupancy
module col_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [1:0][W-1:0] mem;
  logic wp, rp, pop;
  logic [1:0] cnt;
  always_comb begin
    valid = cnt != 2'd0;
    pop = valid && ready;
    dout = mem[rp];
    occ = cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/line_window_ctrl.sv
// line_window_ctrl: raster pixels to NLINES-tall columns over an sramLine bank; LINE_WINDOW_BORDER_REPLICATE_EN also emits top-border columns
module line_window_ctrl
  import line_window_pkg::state_t, line_window_pkg::FILL, line_window_pkg::STREAM, line_window_pkg::rot_idx;
#(
  parameter int WIDTH  = 1920,
  parameter int HEIGHT = 1080,
  parameter int NLINES = 3,
  parameter int DW     = line_window_pkg::DW,
  parameter int AW     = $clog2(WIDTH),
  parameter int HW     = $clog2(HEIGHT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [DW-1:0]               in_data,
  output logic [NLINES-1:0]           sram_wen,
  output logic [NLINES-1:0]           sram_ren,
  output logic [AW-1:0]               sram_addr,
  output logic [DW-1:0]               sram_d,
  input  logic [NLINES-1:0][DW-1:0]   sram_q,
  output logic                        col_valid,
  input  logic                        col_ready,
  output logic [NLINES-1:0][DW-1:0]   col_data,
  output logic [AW-1:0]               col_x,
  output logic [HW-1:0]               col_y,
  output logic                        frame_done
);
  localparam int PW = $clog2(NLINES);
  localparam int CW = NLINES * DW + AW + HW;
  logic [AW-1:0] x, ex, s1_x;
  logic [HW-1:0] y, ey, s1_y;
  logic [PW-1:0] wr_ptr, ep, s1_ptr;
  state_t state, est;
  logic s1_valid, acc, pop, last_x, last, s1_go, rd_en;
  logic [DW-1:0] s1_pix;
  logic [NLINES-1:0][DW-1:0] col_in;
  logic [NLINES-1:0] line_sel;
  logic [1:0] occ;
  // An accepted start-of-frame pixel is placed at (0,0) of a fresh frame.
  always_comb begin
    pop = col_valid && col_ready;
    in_ready = !rst && (3'(s1_valid) + 3'(occ) - 3'(pop) < 3'd2);
    acc = in_valid && in_ready;
    ex = in_sof ? '0 : x;
    ey = in_sof ? '0 : y;
    ep = in_sof ? '0 : wr_ptr;
    est = in_sof ? FILL : state;
    last_x = ex == AW'(WIDTH - 1);
    last = last_x && ey == HW'(HEIGHT - 1);
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    s1_go = acc;
    rd_en = acc && (est == STREAM || ey != '0);
`else
    s1_go = acc && est == STREAM;
    rd_en = s1_go;
`endif
    line_sel = NLINES'(1) << ep;
    sram_wen = acc ? line_sel : '0;
    sram_ren = rd_en ? ~line_sel : '0;
    sram_addr = acc ? ex : '0;
    sram_d = acc ? in_data : '0;
    frame_done = acc && last;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
      wr_ptr <= '0;
      state <= FILL;
      s1_valid <= 1'b0;
      s1_pix <= '0;
      s1_x <= '0;
      s1_y <= '0;
      s1_ptr <= '0;
    end else begin
      s1_valid <= s1_go;
      if (acc) begin
        x <= last_x ? '0 : ex + AW'(1);
        y <= last ? '0 : last_x ? ey + HW'(1) : ey;
        wr_ptr <= last ? '0 : !last_x ? ep : ep == PW'(NLINES - 1) ? '0 : ep + PW'(1);
        state <= last ? FILL : (last_x && ey == HW'(NLINES - 2)) ? STREAM : est;
      end
      if (s1_go) begin
        s1_pix <= in_data;
        s1_x <= ex;
        s1_y <= ey;
        s1_ptr <= ep;
      end
    end
  // Older rows come from the lines after the write line, oldest first.
  always_comb begin
    col_in = '0;
    for (int k = 0; k < NLINES - 1; k++)
      col_in[k] = sram_q[PW'(rot_idx(int'(s1_ptr), k, NLINES))];
    col_in[NLINES-1] = s1_pix;
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    for (int k = 0; k < NLINES - 1; k++)
      if (int'(s1_y) + k < NLINES - 1) col_in[k] = s1_y == '0 ? s1_pix : sram_q[0];
`endif
  end
  col_skid_buf #(.W(CW)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .din   ({col_in, s1_x, s1_y}),
    .ready (col_ready),
    .valid (col_valid),
    .dout  ({col_data, col_x, col_y}),
    .occ   (occ)
  );
endmodule
